// File: rtl/sonic_vc_stream_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_IN virtual-channel streams into one
// registered output stream; a grant is held from SOP to EOP.
module sonic_vc_stream_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 133,
    parameter int unsigned SOP_BIT    = 129,
    parameter int unsigned EOP_BIT    = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0]    out_channel,
    input  logic                         out_ready,
    output logic [NUM_IN-1:0]            grant,
    output logic                         err_no_sop
);

    localparam int unsigned CW = $clog2(NUM_IN);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         last_grant_q, last_grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]         out_channel_q, out_channel_d;
    logic                  err_no_sop_q, err_no_sop_d;

    logic                  load;
    logic                  found;
    logic [CW-1:0]         sel;
    logic [DATA_WIDTH-1:0] beat;
    logic                  xfer;

    always_comb begin
        load  = !out_valid_q || out_ready;
        sel   = '0;
        found = 1'b0;
        if (state_q == ST_LOCKED) begin
            sel   = owner_q;
            found = 1'b1;
        end else begin
            // Outer loop walks priority order starting after the last winner.
            for (int unsigned k = 1; k <= NUM_IN; k++) begin
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (!found && in_valid[i] && ((32'(last_grant_q) + k) % NUM_IN == i)) begin
                        found = 1'b1;
                        sel   = CW'(i);
                    end
                end
            end
        end

        grant = '0;
        beat  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            grant[i] = found && (sel == CW'(i));
            if (sel == CW'(i)) begin
                beat = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        in_ready = {NUM_IN{load}} & grant;
        xfer     = |(in_ready & in_valid);

        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        err_no_sop_d  = err_no_sop_q;

        if (xfer) begin
            last_grant_d  = sel;
            out_valid_d   = 1'b1;
            out_data_d    = beat;
            out_channel_d = sel;
            if (state_q == ST_IDLE) begin
                // A beat without SOP opens a packet as though it carried one.
                if (!beat[SOP_BIT]) begin
                    err_no_sop_d = 1'b1;
                end
                if (!beat[EOP_BIT]) begin
                    state_d = ST_LOCKED;
                    owner_d = sel;
                end
            end else if (beat[EOP_BIT]) begin
                state_d = ST_IDLE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            last_grant_q  <= CW'(NUM_IN - 1);
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            err_no_sop_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            err_no_sop_q  <= err_no_sop_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign err_no_sop  = err_no_sop_q;

endmodule

// File: tb/tb_sonic_vc_stream_arbiter.sv
// Bench for sonic_vc_stream_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_sonic_vc_stream_arbiter;

    localparam int N    = 4;
    localparam int DW   = 133;
    localparam int SOPB = 129;
    localparam int EOPB = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_channel;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            err_no_sop;

    logic [DW-1:0]   din [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int c = 0; c < N; c++) in_data[c*DW +: DW] = din[c];
    end

    sonic_vc_stream_arbiter #(
        .NUM_IN(N),
        .DATA_WIDTH(DW),
        .SOP_BIT(SOPB),
        .EOP_BIT(EOPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_ready(out_ready),
        .grant(grant),
        .err_no_sop(err_no_sop)
    );

    function automatic logic [DW-1:0] mk(int ch, int tag, bit s, bit e);
        logic [DW-1:0] d;
        d        = '0;
        d[31:0]  = ch;
        d[63:32] = tag;
        d[SOPB]  = s;
        d[EOPB]  = e;
        return d;
    endfunction

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        chkd(nm, DW'(act), DW'(exp));
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkd(nm, DW'(act), DW'(exp));
    endtask

    task automatic do_reset();
        in_valid = '0;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [3:0] sop;
        logic [3:0] eop;
        logic       ordy;
        logic [3:0] g;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
    } ob_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          tbl [16];
        int            rx[$];
        int            k;
        logic [3:0]    eg4 [7];
        bit            ov4 [7];
        int            k4  [7];
        ob_t           expq[$];
        int            m_last;
        bit            m_locked;
        int            m_owner;
        bit            m_err;
        int            plen [N];
        int            pidx [N];
        int            pseq [N];
        logic [3:0]    eg;
        int            g;
        bit            ld;
        bit            xf;
        bit            consume;

        tbl[0]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b0111, 4'b0111, 4'b0101, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{4'b0111, 4'b0101, 4'b0101, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b0111, 4'b0101, 4'b0101, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[8]  = '{4'b0111, 4'b0101, 4'b0101, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{4'b0111, 4'b0101, 4'b0111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        tbl[10] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[13] = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3};
        tbl[14] = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) din[c] = '0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chkd("rst_out_data", out_data, '0);
        chk4("rst_out_channel", 4'(out_channel), 4'd0);
        chk1("rst_err_no_sop", err_no_sop, 1'b0);
        chk4("rst_grant", grant, 4'b0000);
        reset = 1'b0;

        // Table: round robin of single-beat packets, a held 5-beat packet, stall.
        for (int r = 0; r < 16; r++) begin
            in_valid  = tbl[r].vld;
            out_ready = tbl[r].ordy;
            for (int c = 0; c < N; c++) din[c] = mk(c, r, tbl[r].sop[c], tbl[r].eop[c]);
            #1;
            chk4($sformatf("tbl%0d_grant", r), grant, tbl[r].g);
            chk4($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].rdy);
            @(posedge clk);
            #1;
            chk1($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
            if (tbl[r].ov) chk4($sformatf("tbl%0d_out_channel", r), 4'(out_channel), 4'(tbl[r].ch));
            if ((tbl[r].rdy & tbl[r].vld) != 4'b0000)
                chkd($sformatf("tbl%0d_out_data", r), out_data,
                     mk(int'(tbl[r].ch), r, tbl[r].sop[tbl[r].ch], tbl[r].eop[tbl[r].ch]));
            @(negedge clk);
        end

        // Backpressure mid-packet: three stalled cycles, every payload exactly once.
        k = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k < 4) ? 4'b0001 : 4'b0000;
            din[0]    = mk(0, 100 + k, k == 0, k == 3);
            #1;
            if (out_valid && out_ready) rx.push_back(int'(out_data[63:32]));
            if (!out_ready) begin
                chk4($sformatf("stall%0d_in_ready", c), in_ready, 4'b0000);
                chk1($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
                chkd($sformatf("stall%0d_out_data", c), out_data, mk(0, 102, 1'b0, 1'b0));
            end
            if (in_valid[0] && in_ready[0]) k++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        chkd("stall_rx_count", DW'(rx.size()), DW'(4));
        for (int i = 0; i < rx.size(); i++) chkd($sformatf("stall_rx%0d", i), DW'(rx[i]), DW'(100 + i));

        // Owner ch3 stalls two cycles; ch0 waits for its EOP, output bubbles.
        eg4 = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        ov4 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        k4  = '{0, 1, -1, -1, 2, 3, -1};
        for (int c = 0; c < 7; c++) begin
            in_valid = {k4[c] >= 0, 1'b0, 1'b0, 1'b1};
            din[0]   = mk(0, 200, 1'b1, 1'b1);
            if (k4[c] >= 0) din[3] = mk(3, 300 + k4[c], k4[c] == 0, k4[c] == 3);
            #1;
            chk4($sformatf("hold%0d_grant", c), grant, eg4[c]);
            chk4($sformatf("hold%0d_in_ready", c), in_ready, eg4[c]);
            @(posedge clk);
            #1;
            chk1($sformatf("hold%0d_out_valid", c), out_valid, ov4[c]);
            if (ov4[c]) chk4($sformatf("hold%0d_out_channel", c), 4'(out_channel), (c == 6) ? 4'd0 : 4'd3);
            @(negedge clk);
        end
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);

        // Non-SOP beat while idle: forwarded, flags a sticky error, then locks.
        in_valid = 4'b0100;
        din[2]   = mk(2, 400, 1'b0, 1'b0);
        #1;
        chk4("nosop_grant", grant, 4'b0100);
        @(posedge clk);
        #1;
        chk1("nosop_out_valid", out_valid, 1'b1);
        chk4("nosop_out_channel", 4'(out_channel), 4'd2);
        chkd("nosop_out_data", out_data, mk(2, 400, 1'b0, 1'b0));
        chk1("nosop_err", err_no_sop, 1'b1);
        @(negedge clk);
        in_valid = 4'b0110;
        din[1]   = mk(1, 401, 1'b1, 1'b1);
        din[2]   = mk(2, 402, 1'b0, 1'b1);
        #1;
        chk4("nosop_lock_grant", grant, 4'b0100);
        @(posedge clk);
        #1;
        chkd("nosop_eop_data", out_data, mk(2, 402, 1'b0, 1'b1));
        @(negedge clk);
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("nosop_sticky%0d", c), err_no_sop, 1'b1);
            @(negedge clk);
        end

        // Reset in the middle of a 6-beat packet.
        do_reset();
        chk1("rst2_err_cleared", err_no_sop, 1'b0);
        for (int b = 0; b < 2; b++) begin
            in_valid = 4'b0010;
            din[1]   = mk(1, 500 + b, b == 0, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        chk1("rst2_pre_out_valid", out_valid, 1'b1);
        din[1] = mk(1, 502, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk1("rst2_async_out_valid", out_valid, 1'b0);
        chkd("rst2_async_out_data", out_data, '0);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 4'b0011;
        din[0]   = mk(0, 600, 1'b1, 1'b1);
        din[1]   = mk(1, 503, 1'b0, 1'b0);
        #1;
        chk4("rst2_first_grant", grant, 4'b0001);
        @(posedge clk);
        #1;
        chk4("rst2_out_channel", 4'(out_channel), 4'd0);
        chkd("rst2_out_data", out_data, mk(0, 600, 1'b1, 1'b1));
        @(negedge clk);
        in_valid = '0;
        @(posedge clk);
        #1;
        chk1("rst2_drain", out_valid, 1'b0);
        @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        m_last   = N - 1;
        m_locked = 1'b0;
        m_owner  = 0;
        m_err    = 1'b0;
        expq.delete();
        for (int c = 0; c < N; c++) begin
            plen[c] = $urandom_range(1, 4);
            pidx[c] = 0;
            pseq[c] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                in_valid[c] = ($urandom_range(0, 9) < 7);
                din[c]      = mk(c, pseq[c], pidx[c] == 0, pidx[c] == plen[c] - 1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ld = (expq.size() == 0) || out_ready;
            g  = -1;
            if (m_locked) g = m_owner;
            else
                for (int j = 1; j <= N; j++)
                    if (g < 0 && in_valid[(m_last + j) % N]) g = (m_last + j) % N;
            eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk4("rnd_grant", grant, eg);
            chk4("rnd_in_ready", in_ready, ld ? eg : 4'b0000);
            xf      = ld && g >= 0 && in_valid[g];
            consume = (expq.size() != 0) && out_ready;
            @(posedge clk);
            #1;
            if (consume) void'(expq.pop_front());
            if (xf) begin
                expq.push_back('{din[g], g});
                m_last = g;
                if (!m_locked) begin
                    if (!din[g][SOPB]) m_err = 1'b1;
                    if (!din[g][EOPB]) begin
                        m_locked = 1'b1;
                        m_owner  = g;
                    end
                end else if (din[g][EOPB]) begin
                    m_locked = 1'b0;
                end
                pidx[g]++;
                pseq[g]++;
                if (pidx[g] == plen[g]) begin
                    pidx[g] = 0;
                    plen[g] = $urandom_range(1, 4);
                end
            end
            chk1("rnd_out_valid", out_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                chkd("rnd_out_data", out_data, expq[0].d);
                chk4("rnd_out_channel", 4'(out_channel), 4'(expq[0].ch));
            end
            chk1("rnd_err", err_no_sop, m_err);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
